// File: rtl/position_report_tx_pkg.sv
// Shared constants and types for the servo position report frame. The host-side decoder
// uses the same header, frame length and baud constants.
package position_report_tx_pkg;

    localparam logic [7:0] REPORT_HEADER     = 8'hA5;
    localparam int         REPORT_LEN        = 7;
    localparam int         CLKS_PER_BIT_500K = 100;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef struct packed {
        logic [7:0] loc_1;
        logic [7:0] loc_2;
        logic [7:0] loc_3;
        logic [7:0] loc_4;
        logic [7:0] action;
        logic [7:0] checksum;
    } report_snap_t;

    function automatic logic [7:0] report_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                                   input logic [7:0] b3, input logic [7:0] b4,
                                                   input logic [7:0] b5);
        return b1 + b2 + b3 + b4 + b5;
    endfunction

    function automatic logic [7:0] report_byte(input logic [2:0] idx, input report_snap_t snap);
        case (idx)
            3'd0:    return REPORT_HEADER;
            3'd1:    return snap.loc_1;
            3'd2:    return snap.loc_2;
            3'd3:    return snap.loc_3;
            3'd4:    return snap.loc_4;
            3'd5:    return snap.action;
            3'd6:    return snap.checksum;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 transmitter for a single byte. A start accepted in the last stop-bit cycle chains the
// next byte with no idle gap; done is high during that last stop-bit cycle.
module uart_byte_tx
    import position_report_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_500K
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_PRE  = CW'(CLKS_PER_BIT - 2);

    tx_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_done;

    // NOTE: all state updates use <= so every branch sees the pre-edge values of r_cnt/r_shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (start) begin
                        r_state <= TX_START;
                        r_tx    <= 1'b0;
                        r_shift <= data;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end
                end
                TX_START: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= TX_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    // done is raised one cycle early so it is registered yet aligned with the final stop cycle
                    if (r_cnt == CNT_PRE) r_done <= 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (start) begin
                            r_state <= TX_START;
                            r_tx    <= 1'b0;
                            r_shift <= data;
                            r_bit   <= '0;
                        end else begin
                            r_state <= TX_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign tx   = r_tx;
    assign done = r_done;

endmodule

// File: rtl/position_report_tx.sv
// Sends a 7-byte checksummed snapshot of servo positions and the last action byte to the
// host over UART, on request or from a periodic timer.
module position_report_tx
    import position_report_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_500K,
    parameter int REPORT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] location_1,
    input  logic [7:0] location_2,
    input  logic [7:0] location_3,
    input  logic [7:0] location_4,
    input  logic [7:0] action,
    input  logic       report_req,
    input  logic       periodic_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int            TW        = $clog2(REPORT_PERIOD);
    localparam logic [TW-1:0] TIMER_MAX = TW'(REPORT_PERIOD - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(REPORT_LEN - 1);

    logic [TW-1:0] r_timer;
    logic          r_busy;
    logic          r_pending;
    logic          r_frame_done;
    logic [2:0]    r_idx;
    report_snap_t  r_snap;

    logic          w_byte_done;
    logic          w_tick;
    logic          w_req;
    logic          w_last_byte;
    logic          w_frame_start;
    logic          w_start;
    logic [2:0]    w_next_idx;
    logic [7:0]    w_data;
    report_snap_t  w_capture;

    assign w_tick        = periodic_en && (r_timer == TIMER_MAX);
    assign w_req         = report_req || w_tick;
    assign w_last_byte   = r_busy && w_byte_done && (r_idx == LAST_IDX);
    // A frame starts from idle, or chains straight on when a request is waiting at frame end
    assign w_frame_start = (!r_busy && w_req) || (w_last_byte && (r_pending || w_req));
    assign w_start       = w_frame_start || (r_busy && w_byte_done && (r_idx != LAST_IDX));
    assign w_next_idx    = w_frame_start ? 3'd0 : r_idx + 3'd1;
    assign w_data        = report_byte(w_next_idx, r_snap);

    assign w_capture = '{
        loc_1:    location_1,
        loc_2:    location_2,
        loc_3:    location_3,
        loc_4:    location_4,
        action:   action,
        checksum: report_checksum(location_1, location_2, location_3, location_4, action)
    };

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!periodic_en || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // NOTE: the snapshot is pure data qualified by busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_frame_start) r_snap <= w_capture;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_frame_done <= w_last_byte;
            if (w_frame_start) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
            end else if (w_last_byte) begin
                r_busy <= 1'b0;
            end else if (r_busy && w_byte_done) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_last_byte) begin
                r_pending <= 1'b0;
            end else if (r_busy && w_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_byte_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .data  (w_data),
        .tx    (tx),
        .done  (w_byte_done)
    );

    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
